// File: rtl/uart_byte_fifo_if.sv
// Byte stream bundle between the UART receiver, the FIFO and the byte consumer.
// Latency: none, this is only wiring.
// Backpressure: out_ready throttles the consumer side; the write side has no ready.
interface uart_byte_fifo_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  // Producer/consumer side: writes bytes and accepts the head.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data
  );

  // FIFO side.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/uart_byte_fifo.sv
// First-word-fall-through byte queue between the UART rx strobe and a valid/ready consumer.
// Latency: a byte written at edge N is on out_data with out_valid=1 after edge N.
// Backpressure: none upstream; a byte arriving while full with no pop is dropped and counted.
module uart_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  uart_byte_fifo_if.slave  bus,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  input  logic             clr_overflow,
  output logic [7:0]       drop_cnt
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic             drop;

  // Status decodes come from the count register only, never from pointer compare.
  assign empty         = (count == '0);
  assign full          = (count == CNT_W'(DEPTH));
  assign bus.out_valid = !empty;
  assign bus.out_data  = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a write to a full FIFO that is
  // being drained is accepted rather than dropped.
  assign pop  = bus.out_valid && bus.out_ready;
  assign push = bus.in_valid && (!full || pop);
  assign drop = bus.in_valid && full && !pop;

  // Storage write; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // Pointers wrap modulo DEPTH through natural overflow of their width.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow and saturating drop counter; a drop beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_overflow)           drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_uart_byte_fifo.sv
// Self-checking bench for uart_byte_fifo with a queue scoreboard.
// Each cycle the model predicts push/pop/drop from its own occupancy.
// Status and head byte are compared one step after every clock edge.
module tb_uart_byte_fifo;
  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             clr_overflow;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic [7:0]       drop_cnt;

  uart_byte_fifo_if #(.WIDTH(WIDTH)) bus ();

  uart_byte_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .drop_cnt     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard and reference state
  logic [7:0] q[$];
  logic       m_ovf;
  int         m_drop;
  logic [7:0] last_out;
  int         n_checks;
  int         n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_state();
    check("count",     32'(count),         32'(q.size()));
    check("empty",     32'(empty),         32'(q.size() == 0));
    check("full",      32'(full),          32'(q.size() == DEPTH));
    check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    check("overflow",  32'(overflow),      32'(m_ovf));
    check("drop_cnt",  32'(drop_cnt),      32'(m_drop));
    if (q.size() != 0) check("head", 32'(bus.out_data), 32'(q[0]));
  endtask

  // One clock with the given inputs; model updated from its own pre-edge state.
  task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy, input logic clr);
    logic full_m, pop_m, push_m, drop_m;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    clr_overflow  = clr;
    full_m = (q.size() == DEPTH);
    pop_m  = (q.size() != 0) && ordy;
    push_m = iv && (!full_m || pop_m);
    drop_m = iv && full_m && !pop_m;
    if (pop_m) last_out = q.pop_front();
    if (push_m) q.push_back(d);
    if (drop_m) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    clr_overflow  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
    check_state();
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 2 && q.size() != 0; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("drained", 32'(empty), 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_ovf    = 1'b0;
    m_drop   = 0;
    last_out = '0;

    // Reset state
    do_reset();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);

    // Three bytes held, then drained in order
    cycle(1'b1, 8'h41, 1'b0, 1'b0);
    cycle(1'b1, 8'h42, 1'b0, 1'b0);
    cycle(1'b1, 8'h43, 1'b0, 1'b0);
    check("t1_count", 32'(count), 32'd3);
    check("t1_head", 32'(bus.out_data), 32'h41);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("t1_stable", 32'(bus.out_data), 32'h41);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("t1_last", 32'(last_out), 32'h43);
    check("t1_empty", 32'(empty), 32'd1);

    // Fill to full, drop 0xFF, drain
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    check("t2_full", 32'(full), 32'd1);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    check("t2_ovf", 32'(overflow), 32'd1);
    check("t2_drop", 32'(drop_cnt), 32'd1);
    check("t2_count", 32'(count), 32'd16);
    drain();
    check("t2_last", 32'(last_out), 32'h0F);

    // Full with simultaneous push and pop: nothing dropped
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    check("t3_ovf", 32'(overflow), 32'd0);
    check("t3_count", 32'(count), 32'd16);
    drain();
    check("t3_last", 32'(last_out), 32'hAA);

    // Pointer wrap with interleaved pops
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'(8'h80 + i), (i % 3) != 0, 1'b0);
      check("t4_bound", 32'(count <= CNT_W'(DEPTH)), 32'd1);
    end
    drain();
    check("t4_last", 32'(last_out), 32'(8'h80 + 39));

    // Saturating drop counter and clear precedence
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) cycle(1'b1, 8'($urandom_range(255)), 1'b0, 1'b0);
    check("t5_sat", 32'(drop_cnt), 32'd255);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("t5_clr_ovf", 32'(overflow), 32'd0);
    check("t5_clr_cnt", 32'(drop_cnt), 32'd0);
    cycle(1'b1, 8'h77, 1'b0, 1'b1);
    check("t5_race_ovf", 32'(overflow), 32'd1);
    check("t5_race_cnt", 32'(drop_cnt), 32'd1);
    drain();

    // Out_ready while empty is ignored
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("t6_idle", 32'(count), 32'd0);

    // Reset mid-operation discards queued bytes
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    do_reset();
    check("t7_count", 32'(count), 32'd0);
    check("t7_ovf", 32'(overflow), 32'd0);
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    check("t7_head", 32'(bus.out_data), 32'h55);
    check("t7_valid", 32'(bus.out_valid), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_byte_fifo.md
Name: uart_byte_fifo

Overview:
Synchronous byte FIFO between the UART receiver (single-cycle rx_valid/rx_data strobe, no backpressure) and the UART transmitter or other byte consumers. It absorbs back-to-back received bytes while the consumer is busy, so echo no longer drops characters. It presents a first-word-fall-through valid/ready output and reports overflow when bytes arrive while it is full.

Parameters:
DEPTH, 16, number of entries; power of two, >= 2
WIDTH, 8, data width in bits
CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived; not overridden)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  single-cycle write strobe from the receiver
in_data  input  WIDTH  byte to write; sampled when in_valid=1
out_valid  output  1  head entry is present on out_data
out_data  output  WIDTH  head-of-queue byte; don't-care when out_valid=0
out_ready  input  1  consumer accepts head this cycle
count  output  CNT_W  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky; set when a byte is dropped
clr_overflow  input  1  clears overflow and drop_cnt
drop_cnt  output  8  saturating count of dropped bytes

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, out_valid=0, overflow=0, drop_cnt=0. Storage contents are not cleared. Reset mid-operation discards all queued bytes; the first accepted write after reset appears at the head.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH naturally. Occupancy comes from the count register, not from pointer comparison.
- push = in_valid && (!full || pop). pop = out_valid && out_ready.
- On push: mem[wr_ptr] <= in_data; wr_ptr++.
- On pop: rd_ptr++.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- full, empty and out_valid are combinational decodes of the count register (out_valid = !empty). They reflect the state after the previous edge.
- FWFT: out_data = mem[rd_ptr] combinationally. With an empty FIFO, a byte written at edge N is on out_data with out_valid=1 after edge N (one-cycle latency). There is no bypass in the same cycle as the write.
- Simultaneous push and pop:
  - When full: both happen, and the byte is NOT dropped. Count stays at DEPTH.
  - When empty: no pop occurs, because out_valid=0. The push proceeds.
- out_ready while empty is ignored. Pointers and count are unchanged.
- Overflow: in_valid=1 && full && !pop means the byte is discarded. overflow <= 1 and drop_cnt <= drop_cnt+1, saturating at 255.
- clr_overflow=1 sets overflow <= 0 and drop_cnt <= 0. If a drop occurs in the same cycle, the drop wins: overflow=1, drop_cnt=1.
- out_data must remain stable while out_valid=1 and out_ready=0.
- No internal state machine beyond the pointers and count. All registers are in one clock domain.

Test Plan:
- Reset, then write 0x41,0x42,0x43 on consecutive cycles with out_ready=0 -> count=3, out_valid=1, out_data=0x41, empty=0. Then hold out_ready=1 for 3 cycles -> out_data sequence 0x41,0x42,0x43, then empty=1 and count=0.
- Write 16 bytes 0x00..0x0F with out_ready=0 -> full=1, count=16. A 17th write of 0xFF -> dropped: overflow=1, drop_cnt=1, count=16. Drain all -> sequence 0x00..0x0F, with 0xFF never seen.
- Full FIFO, in_valid=1 (0xAA) and out_ready=1 in the same cycle -> overflow stays 0, count stays 16. After draining, 0xAA is the last byte out.
- Write 40 bytes interleaved with pops to force pointer wrap -> output order matches input order exactly, and count never exceeds 16.
- Force 300 drops -> drop_cnt saturates at 255. Pulse clr_overflow with no concurrent drop -> overflow=0, drop_cnt=0. Pulse clr_overflow in the same cycle as a drop -> overflow=1, drop_cnt=1.
- With 5 bytes queued, assert rst for 1 cycle -> count=0, empty=1, out_valid=0, overflow=0. A next write of 0x55 -> out_data=0x55 one cycle later.
